univ_reg: RTL and testbench

- Parametrised successor to the SAP-1 8-bit load/clear register.
- Adds multi-cycle shift/rotate by N, increment/decrement, serial fill, carry/zero flags and a start/busy/done handshake.
- Serves as accumulator, B register or output register in the SAP-1 datapath.
- Shifts run one bit per clock under a small FSM so no barrel shifter is needed.

---
 rtl/univ_reg_pkg.sv | 42 ++++
 rtl/univ_reg_step.sv | 67 ++++++
 rtl/univ_reg.sv | 115 +++++++++++
 tb/tb_univ_reg.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// univ_reg shared types: op codes, FSM states.
// Imported by univ_reg and univ_reg_step.
package univ_reg_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  typedef enum logic [2:0] {
    E_NOP  = OP_NOP,
    E_LOAD = OP_LOAD,
    E_SHL  = OP_SHL,
    E_SHR  = OP_SHR,
    E_ROL  = OP_ROL,
    E_ROR  = OP_ROR,
    E_INC  = OP_INC,
    E_DEC  = OP_DEC
  } op_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

  function automatic logic is_shift(
    input logic [2:0] op
  );
    return (op == OP_SHL) || (op == OP_SHR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/univ_reg_step.sv
// univ_reg_step: one combinational step of the register.
// Covers a single shift/rotate bit or a single-cycle op.
module univ_reg_step
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d_in,
  input  logic             carry_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next,
  output logic             carry_next
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE =
    {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] inc_w;
  logic [WIDTH:0] dec_w;

  assign inc_w = {1'b0, q} + ONE;
  assign dec_w = {1'b0, q} - ONE;

  // next value and carry for the selected op
  always_comb begin
    q_next     = q;
    carry_next = carry_in;
    unique case (1'b1)
      (op == OP_LOAD): begin
        q_next     = d_in;
        carry_next = 1'b0;
      end
      (op == OP_SHL): begin
        q_next     = {q[MSB-1:0], ser_in};
        carry_next = q[MSB];
      end
      (op == OP_SHR): begin
        q_next     = {ser_in, q[MSB:1]};
        carry_next = q[0];
      end
      (op == OP_ROL): begin
        q_next     = {q[MSB-1:0], q[MSB]};
        carry_next = q[MSB];
      end
      (op == OP_ROR): begin
        q_next     = {q[0], q[MSB:1]};
        carry_next = q[0];
      end
      (op == OP_INC): begin
        q_next     = inc_w[MSB:0];
        carry_next = inc_w[WIDTH];
      end
      (op == OP_DEC): begin
        q_next     = dec_w[MSB:0];
        carry_next = dec_w[WIDTH];
      end
      default: begin
        q_next     = q;
        carry_next = carry_in;
      end
    endcase
  end

endmodule

// File: rtl/univ_reg.sv
// univ_reg: SAP-1 style universal register with FSM shifts.
// Define UNIV_REG_BUS_OE_EN to add oe / tri-state bus_out.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
`ifdef UNIV_REG_BUS_OE_EN
  ,
  input  logic             oe,
  output wire  [WIDTH-1:0] bus_out
`endif
);

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE =
    {{(AMT_W-1){1'b0}}, 1'b1};

  state_e           state;
  op_e              op_r;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] amt_c;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] q_step;
  logic             c_step;
  logic             shift_op;

  // amounts above WIDTH behave as WIDTH
  always_comb begin
    amt_c = amt;
    if (amt > AMT_MAX) amt_c = AMT_MAX;
  end

  assign step_op  = (state == S_IDLE) ? op : op_r;
  assign shift_op = is_shift(op);

  univ_reg_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op        (step_op),
    .q         (q),
    .d_in      (d_in),
    .carry_in  (carry),
    .ser_in    (ser_in),
    .q_next    (q_step),
    .carry_next(c_step)
  );

  // FSM, step counter and data/carry registers
  always_ff @(posedge clk) begin
    if (clr) begin
      q     <= '0;
      carry <= 1'b0;
      state <= S_IDLE;
      cnt   <= '0;
      op_r  <= E_NOP;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_r <= op_e'(op);
            if (shift_op) begin
              if (amt_c != '0) begin
                q     <= q_step;
                carry <= c_step;
                cnt   <= amt_c - AMT_ONE;
              end else begin
                cnt <= '0;
              end
              state <= (amt_c > AMT_ONE) ? S_SHIFT : S_DONE;
            end else begin
              q     <= q_step;
              carry <= c_step;
              state <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          q     <= q_step;
          carry <= c_step;
          cnt   <= cnt - AMT_ONE;
          if (cnt == AMT_ONE) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign zero = (q == '0);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

`ifdef UNIV_REG_BUS_OE_EN
  assign bus_out = oe ? q : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: directed self-checking bench for univ_reg.
// Expected values are hand-computed for WIDTH=8.
module tb_univ_reg;

  localparam int W = 8;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [A-1:0] amt = '0;
  logic [W-1:0] d_in = '0;
  logic         ser_in = 1'b0;
  logic [W-1:0] q;
  logic         carry;
  logic         zero;
  logic         busy;
  logic         done;
`ifdef UNIV_REG_BUS_OE_EN
  logic         oe = 1'b0;
  wire  [W-1:0] bus_out;
`endif

  int checks = 0;
  int errors = 0;

  univ_reg #(
    .WIDTH(W),
    .AMT_W(A)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .op    (op),
    .amt   (amt),
    .d_in  (d_in),
    .ser_in(ser_in),
    .q     (q),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
`ifdef UNIV_REG_BUS_OE_EN
    ,
    .oe     (oe),
    .bus_out(bus_out)
`endif
  );

  always #5 clk = ~clk;

  // issue one op from IDLE; count busy cycles and done pulses
  task automatic run_op(
    input  logic [2:0]   o,
    input  logic [A-1:0] k,
    input  logic [W-1:0] d,
    output int           bcyc,
    output int           dcnt
  );
    @(negedge clk);
    start = 1'b1;
    op    = o;
    amt   = k;
    d_in  = d;
    @(negedge clk);
    start = 1'b0;
    bcyc  = 0;
    dcnt  = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      if (!busy) break;
      bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int b, n;
    @(negedge clk);
    clr   = 1'b1;
    start = 1'b1;
    op    = 3'b001;
    d_in  = 8'h99;
    repeat (2) @(negedge clk);
    checks++;
    if (q !== 8'h00) begin
      errors++;
      $display("FAIL clr_q got %h want 00", q);
    end
    checks++;
    if (carry !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_cb got c=%b b=%b want 0 0",
               carry, busy);
    end
    checks++;
    if (zero !== 1'b1) begin
      errors++;
      $display("FAIL clr_zero got %b want 1", zero);
    end
    clr   = 1'b0;
    start = 1'b0;
    run_op(3'b001, 4'd0, 8'h25, b, n);
    checks++;
    if (q !== 8'h25 || carry !== 1'b0) begin
      errors++;
      $display("FAIL load got q=%h c=%b want 25 0",
               q, carry);
    end
    checks++;
    if (zero !== 1'b0) begin
      errors++;
      $display("FAIL load_zero got %b want 0", zero);
    end
    checks++;
    if (b !== 1 || n !== 1) begin
      errors++;
      $display("FAIL load_hs got busy=%0d done=%0d want 1 1",
               b, n);
    end
  endtask

  task automatic test_shl();
    int b, n;
    run_op(3'b001, 4'd0, 8'h81, b, n);
    ser_in = 1'b1;
    run_op(3'b010, 4'd3, 8'h00, b, n);
    checks++;
    if (q !== 8'h0F || carry !== 1'b0) begin
      errors++;
      $display("FAIL shl3 got q=%h c=%b want 0f 0",
               q, carry);
    end
    checks++;
    if (b !== 3 || n !== 1) begin
      errors++;
      $display("FAIL shl3_hs got busy=%0d done=%0d want 3 1",
               b, n);
    end
    ser_in = 1'b0;
  endtask

  task automatic test_ror();
    int b, n;
    run_op(3'b001, 4'd0, 8'h81, b, n);
    run_op(3'b101, 4'd8, 8'h00, b, n);
    checks++;
    if (q !== 8'h81 || carry !== 1'b1) begin
      errors++;
      $display("FAIL ror8 got q=%h c=%b want 81 1",
               q, carry);
    end
    checks++;
    if (b !== 8 || n !== 1) begin
      errors++;
      $display("FAIL ror8_hs got busy=%0d done=%0d want 8 1",
               b, n);
    end
  endtask

  task automatic test_clamp();
    int b, n;
    run_op(3'b001, 4'd0, 8'hA5, b, n);
    run_op(3'b100, 4'd15, 8'h00, b, n);
    checks++;
    if (q !== 8'hA5 || carry !== 1'b1) begin
      errors++;
      $display("FAIL rol15 got q=%h c=%b want a5 1",
               q, carry);
    end
    checks++;
    if (b !== 8) begin
      errors++;
      $display("FAIL rol15_busy got %0d want 8", b);
    end
  endtask

  task automatic test_incdec();
    int b, n;
    run_op(3'b001, 4'd0, 8'hFF, b, n);
    run_op(3'b110, 4'd0, 8'h00, b, n);
    checks++;
    if (q !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
      errors++;
      $display("FAIL inc_wrap got q=%h c=%b z=%b want 00 1 1",
               q, carry, zero);
    end
    run_op(3'b010, 4'd0, 8'h00, b, n);
    checks++;
    if (q !== 8'h00 || carry !== 1'b1 || b !== 1) begin
      errors++;
      $display("FAIL amt0 got q=%h c=%b b=%0d want 00 1 1",
               q, carry, b);
    end
    run_op(3'b111, 4'd0, 8'h00, b, n);
    checks++;
    if (q !== 8'hFF || carry !== 1'b1) begin
      errors++;
      $display("FAIL dec_borrow got q=%h c=%b want ff 1",
               q, carry);
    end
    run_op(3'b111, 4'd0, 8'h00, b, n);
    checks++;
    if (q !== 8'hFE || carry !== 1'b0) begin
      errors++;
      $display("FAIL dec got q=%h c=%b want fe 0",
               q, carry);
    end
    run_op(3'b110, 4'd0, 8'h00, b, n);
    checks++;
    if (q !== 8'hFF || carry !== 1'b0) begin
      errors++;
      $display("FAIL inc got q=%h c=%b want ff 0",
               q, carry);
    end
  endtask

  task automatic test_abort();
    int b, n;
    int dn;
    run_op(3'b001, 4'd0, 8'hF7, b, n);
    ser_in = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op    = 3'b011;
    amt   = 4'd5;
    @(negedge clk);
    op    = 3'b001;
    d_in  = 8'h11;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (q !== 8'h3D || busy !== 1'b1) begin
      errors++;
      $display("FAIL shr_mid got q=%h b=%b want 3d 1",
               q, busy);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL abort got q=%h b=%b c=%b want 00 0 0",
               q, busy, carry);
    end
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn !== 0 || q !== 8'h00) begin
      errors++;
      $display("FAIL abort_idle got act=%0d q=%h want 0 00",
               dn, q);
    end
  endtask

  task automatic test_back_to_back();
    int b, n;
    run_op(3'b001, 4'd0, 8'h00, b, n);
    @(negedge clk);
    start = 1'b1;
    op    = 3'b110;
    repeat (4) @(negedge clk);
    start = 1'b0;
    checks++;
    if (q !== 8'h02) begin
      errors++;
      $display("FAIL b2b got q=%h want 02", q);
    end
  endtask

`ifdef UNIV_REG_BUS_OE_EN
  task automatic test_bus_oe();
    int b, n;
    run_op(3'b001, 4'd0, 8'hF7, b, n);
    oe = 1'b0;
    #1;
    checks++;
    if (bus_out !== 8'hzz) begin
      errors++;
      $display("FAIL oe0 got %h want zz", bus_out);
    end
    oe = 1'b1;
    #1;
    checks++;
    if (bus_out !== 8'hF7) begin
      errors++;
      $display("FAIL oe1 got %h want f7", bus_out);
    end
    oe = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_shl();
    test_ror();
    test_clamp();
    test_incdec();
    test_abort();
    test_back_to_back();
`ifdef UNIV_REG_BUS_OE_EN
    test_bus_oe();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
